spi_target_core: RTL and testbench
==================================

# spi_target_core

Parametrised SPI target (slave) that replaces the fixed 8-bit, clock-as-SCK receiver/transmitter. It runs entirely in the system `clk` domain and oversamples an external SCK. Word width, SPI mode and bit order are selectable. It adds a buffered TX handshake, per-word RX strobes, multi-word bursts under one chip-select, and abort/underrun reporting. It sits between the top-level pins and the user logic that consumes and produces SPI words.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits, 4..32.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `MSB_FIRST`, 1: 1 = bit DATA_W-1 first; 0 = bit 0 first.
- `SYNC_STAGES`, 2: synchroniser depth on sck/cs_n/mosi, 2..3.
- `IDLE_MISO`, 1: miso level while not selected.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `sck` in 1: SPI clock, asynchronous.
- `cs_n` in 1: chip select, active low, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out.
- `miso_oe` out 1: high while selected.
- `tx_data` in DATA_W: word to transmit.
- `tx_valid` in 1: tx_data valid.
- `tx_ready` out 1: TX holding buffer empty.
- `rx_data` out DATA_W: last complete received word; held until the next word completes.
- `rx_valid` out 1: one-cycle strobe on word completion.
- `tx_underrun` out 1: one-cycle strobe when a word starts with the buffer empty.
- `frame_abort` out 1: one-cycle strobe when cs_n rises mid-word.
- `busy` out 1: high while selected.

## Operation
- All three pins pass through SYNC_STAGES flops. SCK edges are detected from the last two synchronised samples.
- Leading edge = rising if CPOL=0, falling if CPOL=1.
- Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- States:
  - IDLE: cs_n high. On synchronised cs_n fall, go to LOAD.
  - LOAD: one cycle. Move the holding buffer into the shift register, set bit_cnt=0, go to SHIFT.
  - SHIFT: on each sample edge, capture mosi and increment bit_cnt. When bit_cnt reaches DATA_W: update rx_data, pulse rx_valid, reload the shift register from the buffer (same rules as LOAD), set bit_cnt=0, stay in SHIFT.
  - Synchronised cs_n rise from LOAD or SHIFT returns to IDLE.
- Bit order: the n-th sampled bit goes to index DATA_W-1-n if MSB_FIRST=1, else index n. TX uses the same ordering.
- MISO presentation:
  - CPHA=0: bit 0 of a word is driven in the LOAD cycle; the k-th shift edge drives bit k. The shift edge after a word completes drives bit 0 of the next word.
  - CPHA=1: the k-th shift edge of a word (k from 0) drives bit k.
  - miso is registered. Outside a frame: miso = IDLE_MISO, miso_oe = 0.
- TX buffer:
  - Accepts a word on tx_valid && tx_ready. tx_ready goes low the next cycle.
  - Load into the shift register empties the buffer; tx_ready rises the next cycle.
  - If the buffer is empty at load: shift register = all zeros, pulse tx_underrun.
  - A same-cycle load and new handshake are both honoured; the buffer ends full.
- Abort: cs_n rise with 0 < bit_cnt < DATA_W:
  - pulse frame_abort;
  - discard the partial word; no rx_valid, rx_data unchanged;
  - the in-flight TX word is lost; the holding buffer is kept.
- cs_n rise with bit_cnt = 0: no abort strobe.
- Edges detected while in IDLE are ignored.
- Reset values: miso=IDLE_MISO, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0. Reset empties the buffer and clears the synchronisers to idle levels (cs_n=1, sck=CPOL).
- Reset mid-frame: returns to IDLE next cycle with no strobes.

## Timing
- Pin to internal detection: SYNC_STAGES+1 clk cycles.
- SCK high and low phases each ≥ SYNC_STAGES+2 clk cycles. The minimum clk:SCK ratio is 8 for SYNC_STAGES=2.
- cs_n fall to first SCK edge ≥ SYNC_STAGES+3 clk cycles.
- rx_valid: asserted the cycle after the last sample edge is detected.
- miso change: 1 cycle after the shift edge is detected; SYNC_STAGES+2 cycles after the pin edge.
- busy and miso_oe: follow the synchronised cs_n with 1 cycle of register delay.

## Test plan
- Mode 0, DATA_W=8, MSB first: tx 0xA9 loaded, master sends 0xA5 → rx_valid once with rx_data=0xA5; master samples miso 1,0,1,0,1,0,0,1.
- Mode 3, DATA_W=16, LSB first: tx 0x1234, master sends 0xBEEF → rx_data=0xBEEF; miso LSB-first of 0x1234; tx_ready rises after LOAD.
- Burst: two words under one cs_n, buffer refilled between them → two rx_valid strobes, correct second word, no underrun; a third word without refill → tx_underrun pulse and miso all zeros.
- Abort: cs_n rises after 5 bits → frame_abort pulse, no rx_valid, previous rx_data kept; next frame receives correctly.
- Buffer empty at cs_n fall → tx_underrun at LOAD, zeros shifted; cs_n high → miso=IDLE_MISO, miso_oe=0.
- rst asserted mid-word for 1 cycle → all outputs at reset values next cycle; a following full frame works normally.

Source files
------------

// File: rtl/spi_target_core.sv
// SPI target running entirely in the clk domain: oversampled SCK, selectable width,
// mode and bit order, one-word TX holding buffer, bursts, abort and underrun strobes.
//
// state | meaning
// IDLE  | deselected, miso parked at IDLE_MISO, SCK edges ignored
// LOAD  | one cycle after select: holding buffer moves into the TX word
// SHIFT | selected, sampling mosi / driving miso on detected SCK edges
module spi_target_core #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_MISO   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev, sck_s, cs_s, mosi_s;
  logic                   rise, fall, lead_edge, trail_edge;
  logic                   sample_det, shift_det, mosi_det;
  logic [IDX_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      tx_word, rx_shift, rx_next, buf_data, load_word;
  logic                   buf_full, accept, last_bit, load_now;

  // Position within the word of the n-th bit on the wire
  function automatic logic [IDX_W-1:0] bit_idx(input logic [IDX_W-1:0] n);
    return MSB_FIRST ? IDX_W'(DATA_W - 1) - n : n;
  endfunction

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign rise       = sck_s & ~sck_prev;
  assign fall       = ~sck_s & sck_prev;
  assign lead_edge  = CPOL ? fall : rise;
  assign trail_edge = CPOL ? rise : fall;

  assign tx_ready  = ~buf_full;
  assign accept    = tx_valid & ~buf_full;
  assign load_word = buf_full ? buf_data : '0;
  assign last_bit  = (bit_cnt == IDX_W'(DATA_W - 1));
  assign load_now  = ~cs_s & ((state == ST_LOAD) |
                              ((state == ST_SHIFT) & sample_det & last_bit));

  always_comb begin
    rx_next = rx_shift;
    rx_next[bit_idx(bit_cnt)] = mosi_det;
  end

  // Edge pulses are registered together with mosi so data stays aligned to its edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync   <= {SYNC_STAGES{CPOL}};
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sck_prev   <= CPOL;
      sample_det <= 1'b0;
      shift_det  <= 1'b0;
      mosi_det   <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev   <= sck_s;
      sample_det <= CPHA ? trail_edge : lead_edge;
      shift_det  <= CPHA ? lead_edge : trail_edge;
      mosi_det   <= mosi_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tx_word     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      miso        <= IDLE_MISO;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= ~cs_s;
      miso_oe     <= ~cs_s;

      case (state)
        ST_IDLE: begin
          miso    <= IDLE_MISO;
          bit_cnt <= '0;
          if (!cs_s) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cs_s) begin
            state <= ST_IDLE;
            miso  <= IDLE_MISO;
          end else begin
            state       <= ST_SHIFT;
            bit_cnt     <= '0;
            tx_word     <= load_word;
            tx_underrun <= ~buf_full;
            if (!CPHA) miso <= load_word[bit_idx('0)];
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state <= ST_IDLE;
            miso  <= IDLE_MISO;
            if (bit_cnt != '0) frame_abort <= 1'b1;
          end else if (sample_det) begin
            rx_shift <= rx_next;
            if (last_bit) begin
              rx_data     <= rx_next;
              rx_valid    <= 1'b1;
              tx_word     <= load_word;
              tx_underrun <= ~buf_full;
              bit_cnt     <= '0;
            end else begin
              bit_cnt <= bit_cnt + IDX_W'(1);
            end
          end else if (shift_det) begin
            miso <= tx_word[bit_idx(bit_cnt)];
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A handshake in the same cycle as a load refills the buffer
      if (load_now) buf_full <= 1'b0;
      if (accept) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_core.sv
// Scoreboard bench for spi_target_core: mode 0 / 8-bit MSB-first and mode 3 / 16-bit
// LSB-first instances driven by a bit-banged SPI master.
module tb_spi_target_core;

  localparam int H = 8;
  localparam int K_RX = 0, K_UND = 1, K_ABT = 2;

  typedef struct {
    int          d;
    int          k;
    logic [31:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck0 = 1'b0, cs_n0 = 1'b1, mosi0 = 1'b0, txv0 = 1'b0;
  logic [7:0]  txd0 = '0;
  logic        miso0, oe0, rdy0, rxv0, und0, abt0, busy0;
  logic [7:0]  rxd0;
  logic        sck1 = 1'b1, cs_n1 = 1'b1, mosi1 = 1'b0, txv1 = 1'b0;
  logic [15:0] txd1 = '0;
  logic        miso1, oe1, rdy1, rxv1, und1, abt1, busy1;
  logic [15:0] rxd1;

  int          n_checks = 0;
  int          n_errors = 0;
  ev_t         evq[$];
  logic [31:0] mq[$];
  logic [31:0] got_miso;
  event        miso_ev;

  always #5 clk = ~clk;

  spi_target_core dut0 (
    .clk(clk), .rst(rst), .sck(sck0), .cs_n(cs_n0), .mosi(mosi0),
    .miso(miso0), .miso_oe(oe0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0),
    .rx_data(rxd0), .rx_valid(rxv0), .tx_underrun(und0), .frame_abort(abt0), .busy(busy0));

  spi_target_core #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sck(sck1), .cs_n(cs_n1), .mosi(mosi1),
    .miso(miso1), .miso_oe(oe1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1),
    .rx_data(rxd1), .rx_valid(rxv1), .tx_underrun(und1), .frame_abort(abt1), .busy(busy1));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic got_ev(input int d, input int k, input logic [31:0] v);
    ev_t e;
    if (evq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_strobe: dut%0d kind %0d data %0h, expected none", d, k, v);
      return;
    end
    e = evq.pop_front();
    check("ev_dut", d, e.d);
    check("ev_kind", k, e.k);
    check("ev_data", v, e.v);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rxv0) got_ev(0, K_RX, {24'h0, rxd0});
      if (und0) got_ev(0, K_UND, 0);
      if (abt0) got_ev(0, K_ABT, 0);
      if (rxv1) got_ev(1, K_RX, {16'h0, rxd1});
      if (und1) got_ev(1, K_UND, 0);
      if (abt1) got_ev(1, K_ABT, 0);
    end
  end

  always @(miso_ev) begin
    if (mq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_miso_word: got %0h, expected none", got_miso);
    end else begin
      check("miso_word", got_miso, mq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sck(input int d, input logic v);
    if (d == 0) sck0 = v; else sck1 = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi0 = v; else mosi1 = v;
  endtask

  function automatic logic get_miso(input int d);
    return (d == 0) ? miso0 : miso1;
  endfunction

  task automatic cs_low(input int d);
    if (d == 0) cs_n0 = 1'b0; else cs_n1 = 1'b0;
    tick(10);
  endtask

  task automatic cs_high(input int d);
    tick(H);
    if (d == 0) cs_n0 = 1'b1; else cs_n1 = 1'b1;
    tick(12);
  endtask

  task automatic push(input int d, input logic [31:0] v);
    int n = 0;
    while (((d == 0) ? rdy0 : rdy1) == 1'b0 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) check("push_wait_ready", 0, 1);
    if (d == 0) begin txd0 = v[7:0];  txv0 = 1'b1; end
    else        begin txd1 = v[15:0]; txv1 = 1'b1; end
    tick(1);
    txv0 = 1'b0;
    txv1 = 1'b0;
    check("tx_ready_low_after_push", (d == 0) ? rdy0 : rdy1, 0);
  endtask

  // dut0: mode 0, MSB first, 8 bits; dut1: mode 3, LSB first, 16 bits
  task automatic spi_word(input int d, input logic [31:0] w, input int nbits);
    int          wd   = (d == 0) ? 8 : 16;
    logic        cpol = (d != 0);
    logic        cpha = (d != 0);
    logic [31:0] got  = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx = (d == 0) ? wd - 1 - i : i;
      if (!cpha) begin
        set_mosi(d, w[idx]);
        tick(H);
        got[idx] = get_miso(d);
        set_sck(d, ~cpol);
        tick(H);
        set_sck(d, cpol);
      end else begin
        set_sck(d, ~cpol);
        set_mosi(d, w[idx]);
        tick(H);
        got[idx] = get_miso(d);
        set_sck(d, cpol);
        tick(H);
      end
    end
    if (nbits == wd) begin
      got_miso = got;
      ->miso_ev;
    end
  endtask

  initial begin
    tick(4);
    rst = 1'b0;
    tick(2);
    check("rst_miso0", miso0, 1);
    check("rst_oe0", oe0, 0);
    check("rst_ready0", rdy0, 1);
    check("rst_rxdata0", rxd0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_miso1", miso1, 1);
    check("rst_ready1", rdy1, 1);

    // Mode 0 single word
    mq.push_back(32'hA9);
    evq.push_back('{0, K_RX, 32'hA5});
    evq.push_back('{0, K_UND, 32'h0});
    push(0, 32'hA9);
    cs_low(0);
    check("busy_in_frame", busy0, 1);
    check("oe_in_frame", oe0, 1);
    check("ready_after_load", rdy0, 1);
    spi_word(0, 32'hA5, 8);
    cs_high(0);
    check("rxdata_hold", rxd0, 8'hA5);

    // Burst: refill before word 2, none before word 3
    mq.push_back(32'h11);
    mq.push_back(32'h22);
    mq.push_back(32'h00);
    evq.push_back('{0, K_RX, 32'h3C});
    evq.push_back('{0, K_RX, 32'hC3});
    evq.push_back('{0, K_UND, 32'h0});
    evq.push_back('{0, K_RX, 32'h5A});
    evq.push_back('{0, K_UND, 32'h0});
    push(0, 32'h11);
    cs_low(0);
    push(0, 32'h22);
    spi_word(0, 32'h3C, 8);
    spi_word(0, 32'hC3, 8);
    spi_word(0, 32'h5A, 8);
    cs_high(0);

    // Abort after 5 bits; buffered 0x88 survives into the next frame
    evq.push_back('{0, K_ABT, 32'h0});
    push(0, 32'h77);
    cs_low(0);
    push(0, 32'h88);
    spi_word(0, 32'hFF, 5);
    cs_high(0);
    check("abort_rxdata_kept", rxd0, 8'h5A);
    check("abort_buffer_kept", rdy0, 0);
    mq.push_back(32'h88);
    evq.push_back('{0, K_RX, 32'h69});
    evq.push_back('{0, K_UND, 32'h0});
    cs_low(0);
    spi_word(0, 32'h69, 8);
    cs_high(0);

    // Empty buffer at select
    evq.push_back('{0, K_UND, 32'h0});
    mq.push_back(32'h00);
    evq.push_back('{0, K_RX, 32'h0F});
    evq.push_back('{0, K_UND, 32'h0});
    cs_low(0);
    spi_word(0, 32'h0F, 8);
    cs_high(0);
    check("idle_miso", miso0, 1);
    check("idle_oe", oe0, 0);
    check("idle_busy", busy0, 0);

    // Mode 3, 16-bit, LSB first
    mq.push_back(32'h1234);
    evq.push_back('{1, K_RX, 32'hBEEF});
    evq.push_back('{1, K_UND, 32'h0});
    push(1, 32'h1234);
    cs_low(1);
    check("m3_ready_after_load", rdy1, 1);
    check("m3_oe_in_frame", oe1, 1);
    spi_word(1, 32'hBEEF, 16);
    cs_high(1);
    check("m3_rxdata", rxd1, 16'hBEEF);

    // Reset mid-word, then a normal frame
    push(0, 32'h55);
    cs_low(0);
    spi_word(0, 32'h00, 3);
    rst   = 1'b1;
    cs_n0 = 1'b1;
    sck0  = 1'b0;
    tick(1);
    rst = 1'b0;
    check("mid_rst_miso", miso0, 1);
    check("mid_rst_oe", oe0, 0);
    check("mid_rst_ready", rdy0, 1);
    check("mid_rst_rxdata", rxd0, 0);
    check("mid_rst_strobes", {rxv0, und0, abt0}, 0);
    check("mid_rst_busy", busy0, 0);
    tick(6);
    mq.push_back(32'hC6);
    evq.push_back('{0, K_RX, 32'h3E});
    evq.push_back('{0, K_UND, 32'h0});
    push(0, 32'hC6);
    cs_low(0);
    spi_word(0, 32'h3E, 8);
    cs_high(0);

    tick(20);
    check("events_pending", evq.size(), 0);
    check("miso_words_pending", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
